// File: rtl/cache_read_controller_if.sv
// CPU read port and main-memory block-fetch port of the cache read controller.
// The slave modport is the controller side; the master modport drives CPU requests and memory responses.
interface cache_read_controller_if;
  logic [14:0]  cpuAddress;
  logic         cpuRead;
  logic [31:0]  cpuData;
  logic         cpuReady;
  logic [14:0]  memAddress;
  logic         memRead;
  logic         memDataReady;
  logic [127:0] memDataBlock;

  modport slave (
    input  cpuAddress, cpuRead, memDataReady, memDataBlock,
    output cpuData, cpuReady, memAddress, memRead
  );

  modport master (
    output cpuAddress, cpuRead, memDataReady, memDataBlock,
    input  cpuData, cpuReady, memAddress, memRead
  );
endinterface

// File: rtl/cache_read_controller.sv
// Direct-mapped read-only cache, 4-word lines: a hit completes in 3 cycles; a miss fetches one block over read/dataReady.
// No backpressure: a request is taken only in IDLE, and the CPU holds cpuRead until the one-cycle cpuReady pulse.
module cache_read_controller #(
  parameter int INDEX_BITS = 10,
  parameter int COUNT_BITS = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  cache_read_controller_if.slave bus,
  output logic [COUNT_BITS-1:0]  accessCount,
  output logic [COUNT_BITS-1:0]  hitCount
);
  localparam int TAG_BITS = 13 - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] COMPARE  = 3'd1;
  localparam logic [2:0] MEM_REQ  = 3'd2;
  localparam logic [2:0] MEM_WAIT = 3'd3;
  localparam logic [2:0] FILL     = 3'd4;
  localparam logic [2:0] RESPOND  = 3'd5;

  logic [2:0]          state;
  logic [14:0]         req_addr;
  logic                seen_low;
  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [127:0]        data_mem [LINES];

  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic [1:0]            req_off;
  logic                  hit;

  assign req_idx = req_addr[INDEX_BITS+1:2];
  assign req_tag = req_addr[14:INDEX_BITS+2];
  assign req_off = req_addr[1:0];
  assign hit     = valid[req_idx] && (tag_mem[req_idx] == req_tag);

  // Tag and data arrays carry no reset; the valid bits alone decide whether a line is usable.
  always_ff @(posedge clk) begin
    if (!rst && state == FILL) begin
      data_mem[req_idx] <= bus.memDataBlock;
      tag_mem[req_idx]  <= req_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      req_addr       <= '0;
      seen_low       <= 1'b0;
      valid          <= '0;
      bus.cpuData    <= '0;
      bus.cpuReady   <= 1'b0;
      bus.memAddress <= '0;
      bus.memRead    <= 1'b0;
      accessCount    <= '0;
      hitCount       <= '0;
    end else begin
      bus.cpuReady <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cpuRead) begin
            req_addr <= bus.cpuAddress;
            state    <= COMPARE;
          end
        end
        COMPARE: begin
          if (accessCount != '1) accessCount <= accessCount + COUNT_BITS'(1);
          if (hit) begin
            if (hitCount != '1) hitCount <= hitCount + COUNT_BITS'(1);
            state <= RESPOND;
          end else begin
            state <= MEM_REQ;
          end
        end
        MEM_REQ: begin
          bus.memAddress <= {req_addr[14:2], 2'b00};
          bus.memRead    <= 1'b1;
          seen_low       <= 1'b0;
          state          <= MEM_WAIT;
        end
        MEM_WAIT: begin
          // A dataReady still high from the previous fetch must drop before it counts as completion.
          if (bus.memDataReady && seen_low) begin
            state <= FILL;
          end else if (!bus.memDataReady) begin
            seen_low <= 1'b1;
          end
        end
        FILL: begin
          valid[req_idx] <= 1'b1;
          bus.memRead    <= 1'b0;
          state          <= RESPOND;
        end
        RESPOND: begin
          bus.cpuData  <= data_mem[req_idx][{req_off, 5'b0} +: 32];
          bus.cpuReady <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_read_controller.sv
// Scoreboard bench: expected words queued per request, popped on each cpuReady pulse; behavioural main memory.
module tb_cache_read_controller;
  localparam int CB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CB-1:0] acc_cnt, hit_cnt;

  cache_read_controller_if bus ();

  cache_read_controller #(.INDEX_BITS(10), .COUNT_BITS(CB)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .accessCount (acc_cnt),
    .hitCount    (hit_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] exp_q [$];
  logic [31:0] exp_w;
  int fetches = 0;
  logic [14:0] last_fetch_addr = '0;
  int stale_hold = 0;
  int mem_lat = 8;
  bit mr_seen = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] word_of(input logic [14:0] a);
    return {17'h0, a} ^ 32'h6;
  endfunction

  function automatic logic [127:0] block_of(input logic [14:0] a);
    logic [127:0] b;
    for (int k = 0; k < 4; k++) b[32*k +: 32] = word_of({a[14:2], 2'(k)});
    return b;
  endfunction

  // Main memory: reacts to a memRead rise, optionally leaves the old dataReady up for a while.
  initial begin
    bus.memDataReady = 1'b0;
    bus.memDataBlock = '0;
    forever begin
      @(negedge clk);
      if (bus.memRead && !mr_seen) begin
        mr_seen = 1;
        fetches++;
        last_fetch_addr = bus.memAddress;
        repeat (stale_hold) @(negedge clk);
        bus.memDataReady = 1'b0;
        repeat (mem_lat) @(negedge clk);
        bus.memDataBlock = block_of(last_fetch_addr);
        bus.memDataReady = 1'b1;
      end else if (!bus.memRead) begin
        mr_seen = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.cpuReady) begin
      if (exp_q.size() == 0) chk("sb_unexpected_ready", bus.cpuReady, 1'b0);
      else begin
        exp_w = exp_q.pop_front();
        chk("cpuData", bus.cpuData, exp_w);
      end
    end
  end

  task automatic do_read(input logic [14:0] a, input bit miss, input string tag);
    int f0;
    int cyc;
    f0 = fetches;
    exp_q.push_back(word_of(a));
    bus.cpuAddress = a;
    bus.cpuRead    = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.cpuReady && cyc < 200);
    bus.cpuRead = 1'b0;
    chk({tag, "_ready"}, bus.cpuReady, 1'b1);
    chk({tag, "_fetches"}, fetches - f0, miss ? 1 : 0);
    if (miss) chk({tag, "_memAddress"}, last_fetch_addr, {a[14:2], 2'b00});
    else      chk({tag, "_hit_latency"}, cyc, 3);
    @(negedge clk);
    chk({tag, "_pulse"}, bus.cpuReady, 1'b0);
  endtask

  initial begin
    int cyc;
    bus.cpuAddress = '0;
    bus.cpuRead    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cpuReady", bus.cpuReady, 1'b0);
    chk("rst_cpuData", bus.cpuData, 32'h0);
    chk("rst_memRead", bus.memRead, 1'b0);
    chk("rst_memAddress", bus.memAddress, 15'h0);
    chk("rst_access", acc_cnt, 4'h0);
    chk("rst_hit", hit_cnt, 4'h0);
    rst = 1'b0;
    @(negedge clk);

    do_read(15'h0005, 1, "miss_first");
    chk("miss_first_access", acc_cnt, 4'd1);
    chk("miss_first_hit", hit_cnt, 4'd0);

    do_read(15'h0006, 0, "hit_same_block");
    chk("hit_same_block_access", acc_cnt, 4'd2);
    chk("hit_same_block_hit", hit_cnt, 4'd1);

    do_read(15'h1005, 1, "conflict_new_tag");
    do_read(15'h0005, 1, "conflict_evicted");
    chk("conflict_access", acc_cnt, 4'd4);
    chk("conflict_hit", hit_cnt, 4'd1);

    // dataReady is still high from the last fetch and stays high past the new memRead rise.
    stale_hold = 4;
    do_read(15'h0208, 1, "stale_ready");
    stale_hold = 0;
    chk("stale_access", acc_cnt, 4'd5);

    // Reset in the middle of a fetch.
    bus.cpuAddress = 15'h0410;
    bus.cpuRead    = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.memRead && cyc < 50);
    bus.cpuRead = 1'b0;
    chk("abort_memRead_rise", bus.memRead, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_memRead", bus.memRead, 1'b0);
    chk("abort_access", acc_cnt, 4'd0);
    chk("abort_hit", hit_cnt, 4'd0);
    chk("abort_cpuReady", bus.cpuReady, 1'b0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    do_read(15'h0410, 1, "post_reset");
    chk("post_reset_access", acc_cnt, 4'd1);
    chk("post_reset_hit", hit_cnt, 4'd0);

    for (int i = 0; i < 17; i++) do_read(15'h0410 + 15'(i % 4), 0, "sat_hit");
    chk("sat_access", acc_cnt, 4'hF);
    chk("sat_hit", hit_cnt, 4'hF);

    repeat (3) @(negedge clk);
    chk("sb_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cache_read_controller.md
# cache_read_controller

Direct-mapped, read-only cache controller between the CPU-side read port and `MainMemory`. It holds tag/valid/data arrays for 4-word blocks and answers hits locally. On a miss it sequences one block fetch from main memory over the `read`/`dataReady` handshake, fills the line and returns the requested word. It also keeps access and hit counters for hit-rate measurement.

## Interface
- `INDEX_BITS`, 10: line index width (1024 lines); tag width = 13 − INDEX_BITS.
- `COUNT_BITS`, 16: width of the statistics counters.

- `clk`  in  1: single clock; everything updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `cpuAddress`  in  15: word address; [1:0] word offset, [INDEX_BITS+1:2] index, [14:INDEX_BITS+2] tag.
- `cpuRead`  in  1: level request; sampled only in IDLE.
- `cpuData`  out  32: returned word, valid while `cpuReady`=1.
- `cpuReady`  out  1: one-cycle completion pulse.
- `memAddress`  out  15: block-aligned fetch address ({tag,index,2'b00}).
- `memRead`  out  1: fetch request to main memory; main memory acts on its rising edge.
- `memDataReady`  in  1: main memory completion flag.
- `memDataBlock`  in  128: fetched block; word k at [32k+31:32k].
- `accessCount`  out  COUNT_BITS: accepted requests.
- `hitCount`  out  COUNT_BITS: requests served as hits.

## Operation
- States: IDLE, COMPARE, MEM_REQ, MEM_WAIT, FILL, RESPOND.
- IDLE: when `cpuRead`=1, latch `cpuAddress` into `reqAddr` and go to COMPARE. Otherwise stay in IDLE.
- COMPARE: increment `accessCount`. Hit means valid[index] and tag[index] == reqAddr tag. On a hit, increment `hitCount` and go to RESPOND. On a miss, go to MEM_REQ.
- MEM_REQ: drive `memAddress`, set `memRead`=1, clear the `seenLow` flag, go to MEM_WAIT.
- MEM_WAIT: keep `memRead`=1. Set `seenLow` when `memDataReady`=0. Go to FILL only when `memDataReady`=1 and `seenLow` is already set. This rejects a `memDataReady` left high by the previous fetch.
- FILL: write `memDataBlock` into the data line, write the tag, set valid[index], drop `memRead` to 0, go to RESPOND.
- RESPOND: `cpuData` = word reqAddr[1:0] of the line, `cpuReady`=1 for exactly this cycle, then go to IDLE.
- Counters saturate at all-ones and never wrap.
- Only the latched `reqAddr` is used. `cpuAddress` and `cpuRead` are ignored outside IDLE.
- A fill always replaces the whole line (no partial valid).

## Timing
- Reset values: state IDLE; all valid bits 0; `cpuReady`=0, `cpuData`=0, `memRead`=0, `memAddress`=0, counters 0. Tag and data arrays need no reset.
- Hit latency: request sampled at edge N, `cpuReady` high during cycle N+2, back in IDLE at N+3.
- Miss latency:
  - `memRead` rises at edge N+2.
  - FILL occurs in the cycle after `memDataReady` is first sampled high with `seenLow` already set.
  - `cpuReady` follows one cycle after FILL.
- `memRead` is low for at least 2 cycles (RESPOND, IDLE) before it can rise again. This guarantees a fresh rising edge for main memory.
- If `cpuRead` is still high in the IDLE cycle after `cpuReady`, a new request is accepted. Back-to-back hits therefore complete one every 3 cycles.
- `rst` during MEM_REQ/MEM_WAIT/FILL: next state IDLE, `memRead`=0, the fetch is discarded and no line is marked valid.

## Test plan
- After reset, read 0x0005 (main memory preloaded to 32'h3):
  - `memRead` rises with `memAddress`=0x0004.
  - After ~150 ns `cpuData`=32'h3 with a one-cycle `cpuReady`.
  - `accessCount`=1, `hitCount`=0.
- Then read 0x0006 (same block): `cpuReady` 2 cycles after the request, `memRead` stays 0, `hitCount`=1, `accessCount`=2.
- Read 0x1005 (same index, different tag): miss with `memAddress`=0x1004. A following read of 0x0005 misses again (conflict eviction), giving `hitCount`=1, `accessCount`=4.
- Hold `memDataReady`=1 from the previous fetch into a new miss: the controller stays in MEM_WAIT until the flag goes low then high. No early FILL occurs and `cpuData` comes from the new block.
- Pulse `rst` during MEM_WAIT:
  - `memRead`=0 and counters 0 on the next edge.
  - A re-read of the same address misses (valid bit was not set).
- Force `accessCount` near saturation (COUNT_BITS=4, 17 hits on one address): `accessCount` holds at 4'hF and `hitCount` holds at 4'hF, with no wrap.
